// File: rtl/hex_display_pkg.sv
// Shared constants for the multiplexed hex display: blank pattern, active-low
// gfedcba glyph table and a width helper that never returns zero.
package hex_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low seven-segment decoder (bit0 = a .. bit6 = g).
module hex_seg_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_display_scan.sv
// Multi-digit hex display scanner: shadow registers, refresh prescaler, guard
// interval and registered pins. Optional leading-zero blanking: HEX_SCAN_LZ_BLANK_EN.
module hex_display_scan
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      enable,
    input  logic                                      load,
    input  logic [4*NUM_DIGITS-1:0]                   value_in,
    input  logic [NUM_DIGITS-1:0]                     blank_in,
    input  logic [NUM_DIGITS-1:0]                     dp_in,
    output logic [6:0]                                seg,
    output logic                                      dp,
    output logic [NUM_DIGITS-1:0]                     an,
    output logic [clog2_min1(NUM_DIGITS)-1:0]         digit_idx
);

    localparam int IDX_W = clog2_min1(NUM_DIGITS);
    localparam int PRE_W = clog2_min1(REFRESH_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [31:0]      GUARD_U  = GUARD_CYCLES;

    logic [4*NUM_DIGITS-1:0] value_sh;
    logic [NUM_DIGITS-1:0]   blank_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [NUM_DIGITS-1:0]   eff_blank;
    logic [PRE_W-1:0]        pre;
    logic [IDX_W-1:0]        idx;
    logic [3:0]              cur_nibble;
    logic                    cur_blank;
    logic                    cur_dp;
    logic                    in_guard;
    logic [6:0]              dec_seg;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;

    // load is a plain one-cycle strobe with no ready: it is always accepted,
    // whether or not scanning is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_sh <= '0;
            blank_sh <= '0;
            dp_sh    <= '0;
        end else if (load) begin
            value_sh <= value_in;
            blank_sh <= blank_in;
            dp_sh    <= dp_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else if (enable) begin
            if (pre == PRE_LAST) begin
                pre <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

`ifdef HEX_SCAN_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_sup;

    // Suppression runs from the most-significant digit down and stops at the
    // first non-zero digit or lit decimal point; digit 0 always shows.
    always_comb begin
        logic run;
        run    = 1'b1;
        lz_sup = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run       = run & (value_sh[4*i +: 4] == 4'h0) & ~dp_sh[i];
            lz_sup[i] = run;
        end
    end

    assign eff_blank = blank_sh | lz_sup;
`else
    assign eff_blank = blank_sh;
`endif

    always_comb begin
        cur_nibble = '0;
        cur_blank  = 1'b0;
        cur_dp     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nibble = value_sh[4*i +: 4];
                cur_blank  = eff_blank[i];
                cur_dp     = dp_sh[i];
            end
        end
    end

    hex_seg_decode u_decode (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    assign in_guard = ({{(32-PRE_W){1'b0}}, pre} < GUARD_U);

    always_comb begin
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
        an_nxt  = '1;
        if (enable && !in_guard) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_nxt[i] = (idx != IDX_W'(i));
            end
            if (!cur_blank) begin
                seg_nxt = dec_seg;
                dp_nxt  = ~cur_dp;
            end
        end
    end

    // Pins are fully registered so a reset or enable drop never leaves a partial digit lit.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            seg <= seg_nxt;
            dp  <= dp_nxt;
            an  <= an_nxt;
        end
    end

    assign digit_idx = idx;

endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan (4 digits, 4-cycle slots, 1 guard cycle) against a
// position-based reference model; honours HEX_SCAN_LZ_BLANK_EN when defined.
module tb_hex_display_scan;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int GC = 1;
    localparam int W  = 14;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          load;
    logic [15:0]   value_in;
    logic [3:0]    blank_in;
    logic [3:0]    dp_in;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic [1:0]    digit_idx;

    hex_display_scan #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .value_in  (value_in),
        .blank_in  (blank_in),
        .dp_in     (dp_in),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .digit_idx (digit_idx)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: glyphs straight from the gfedcba table
    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          m_pos   = 0;
    bit          m_valid = 0;
    logic [15:0] m_val;
    logic [3:0]  m_blk;
    logic [3:0]  m_dp;
    logic [W-1:0] exp_q[$];

    function automatic bit model_blanked(input int d);
        bit sup;
        if (m_blk[d]) return 1'b1;
        sup = 1'b0;
`ifdef HEX_SCAN_LZ_BLANK_EN
        if (d != 0) begin
            sup = 1'b1;
            for (int j = d; j < ND; j++)
                if (m_val[4*j +: 4] != 4'h0 || m_dp[j]) sup = 1'b0;
        end
`endif
        return sup;
    endfunction

    // scoreboard: expected pins from the pre-edge model state, checked #1 after the edge
    always @(posedge clk) begin
        logic [3:0]   e_an;
        logic [6:0]   e_seg;
        logic         e_dp;
        logic [W-1:0] e;
        logic [W-1:0] g;
        int           d;
        int           p;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e     = '0;
        if (rst) begin
            m_pos   = 0;
            m_val   = '0;
            m_blk   = '0;
            m_dp    = '0;
            m_valid = 1'b1;
            e       = {2'd0, 4'hF, 7'h7F, 1'b1};
        end else if (m_valid) begin
            if (enable) begin
                d = (m_pos / RD) % ND;
                p = m_pos % RD;
                if (p >= GC) begin
                    e_an = 4'hF & ~(4'b0001 << d);
                    if (!model_blanked(d)) begin
                        e_seg = glyph[m_val[4*d +: 4]];
                        e_dp  = ~m_dp[d];
                    end
                end
                m_pos++;
            end
            if (load) begin
                m_val = value_in;
                m_blk = blank_in;
                m_dp  = dp_in;
            end
            e = {2'((m_pos / RD) % ND), e_an, e_seg, e_dp};
        end
        if (m_valid) begin
            exp_q.push_back(e);
            #1;
            g = {digit_idx, an, seg, dp};
            e = exp_q.pop_front();
            check_val("digit_idx", 32'(g[13:12]), 32'(e[13:12]));
            check_val("an",        32'(g[11:8]),  32'(e[11:8]));
            check_val("seg",       32'(g[7:1]),   32'(e[7:1]));
            check_val("dp",        32'(g[0]),     32'(e[0]));
        end
    end

    // driver tasks (called at negedge)
    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] b, input logic [3:0] p);
        value_in = v;
        blank_in = b;
        dp_in    = p;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_scan_pos(input int d, input int p);
        int k;
        for (k = 0; k < 64; k++) begin
            if ((m_pos / RD) % ND == d && m_pos % RD == p) break;
            @(negedge clk);
        end
        if (k == 64) check_val("wait_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [15:0] rand_value();
        logic [15:0] v;
        for (int i = 0; i < ND; i++)
            v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        return v;
    endfunction

    initial begin
        logic [11:0] upper;
        rst      = 1'b1;
        enable   = 1'b0;
        load     = 1'b0;
        value_in = '0;
        blank_in = '0;
        dp_in    = '0;
        run(2);
        rst = 1'b0;
        run(20);

        enable = 1'b1;
        do_load(16'h1A3F, 4'b0000, 4'b0000);
        run(20);

        for (int n = 0; n < 16; n++) begin
            upper = 12'($urandom);
            do_load({upper, 4'(n)}, 4'b0000, 4'($urandom));
            run(16);
        end

        do_load(rand_value(), 4'b0100, 4'b0001);
        run(16);

        do_load(16'hC4D8, 4'b0000, 4'b0010);
        wait_scan_pos(1, 2);
        enable = 1'b0;
        run(5);
        enable = 1'b1;
        run(6);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(8);

        do_load(16'h0050, 4'b0000, 4'b0000);
        run(16);
        do_load(16'h0000, 4'b0000, 4'b0000);
        run(16);
        do_load(16'h0005, 4'b0000, 4'b0100);
        run(16);

        for (int c = 0; c < 400; c++) begin
            enable = ($urandom_range(0, 9) != 0);
            rst    = ($urandom_range(0, 99) == 0);
            load   = ($urandom_range(0, 5) == 0);
            if (load) begin
                value_in = rand_value();
                blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
                dp_in    = 4'($urandom);
            end
            @(negedge clk);
        end
        rst    = 1'b0;
        load   = 1'b0;
        enable = 1'b1;
        run(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
